// File: rtl/sqrt_top.sv
// sqrt_top: bit-serial integer square root of a 7-bit radicand.
// One root bit is resolved per clock, MSB first. A result appears a fixed
// 4 cycles after the launch edge and is held until the next completion.
module sqrt_top (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [6:0] num,
  output logic       ready,
  output logic [3:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] operand_q, operand_d;
  logic [3:0] root_q, root_d;
  logic [1:0] idx_q, idx_d;
  logic       ready_q, ready_d;
  logic [3:0] result_q, result_d;

  // Trial root for the bit currently being resolved, and its square.
  // Eight bits hold 15*15 = 225 without overflow.
  logic [3:0] trial;
  logic [7:0] trial_sq;
  logic       keep_bit;
  logic [3:0] root_new;

  // Trial square and keep/drop decision for the current bit.
  always_comb begin
    trial    = root_q | (4'd1 << idx_q);
    trial_sq = {4'd0, trial} * {4'd0, trial};
    keep_bit = (trial_sq <= {1'b0, operand_q});
    root_new = keep_bit ? trial : root_q;
  end

  // Next-state logic: launch in IDLE, one bit per cycle in CALC,
  // wait for start to drop in DONE so a held start cannot retrigger.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    root_d    = root_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = num;
          root_d    = 4'd0;
          idx_d     = 2'd3;
          ready_d   = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        root_d = root_new;
        idx_d  = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          result_d = root_new;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; clear low aborts everything at once.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      operand_q <= 7'd0;
      root_q    <= 4'd0;
      idx_q     <= 2'd0;
      ready_q   <= 1'b0;
      result_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      root_q    <= root_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_sqrt_top.sv
// tb_sqrt_top: scoreboard bench for sqrt_top. Launches push the expected
// root and launch cycle into a queue; a monitor pops on each rising ready.
module tb_sqrt_top;

  logic       clk;
  logic       clear;
  logic       start;
  logic [6:0] num;
  logic       ready;
  logic [3:0] result;

  sqrt_top dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .num    (num),
    .ready  (ready),
    .result (result)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int completions = 0;

  typedef struct {
    logic [3:0] root;
    int         launch_cyc;
    logic [6:0] n;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on each rising ready, pop the expected entry and compare.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready && !prev_ready) begin
      completions = completions + 1;
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_ready: ready rose with result=%0d, no launch outstanding", result);
      end else begin
        e = sb_q.pop_front();
        if (result !== e.root) begin
          errors = errors + 1;
          $display("FAIL root num=%0d: got %0d, expected %0d", e.n, result, e.root);
        end else begin
          $display("check root num=%0d: result=%0d ok", e.n, result);
        end
        checks = checks + 1;
        if (cyc - e.launch_cyc != 4) begin
          errors = errors + 1;
          $display("FAIL latency num=%0d: got %0d cycles, expected 4", e.n, cyc - e.launch_cyc);
        end
      end
    end
    prev_ready = ready;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("check %s: %0d ok", name, got);
    end
  endtask

  // Wait (bounded) for ready high; leaves us at a negedge.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: ready=%b after %0d cycles, expected 1", name, ready, n);
    end
  endtask

  // Pulse start for one edge with operand n; verify ready drops on launch.
  task automatic launch(input logic [6:0] n, input logic [3:0] root, input string name);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    num   = n;
    e.root = root; e.launch_cyc = cyc + 1; e.n = n;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    num   = 7'h55;
    check({name, "_ready_low_in_calc"}, {3'd0, ready}, 4'd0);
    wait_ready(name);
  endtask

  initial begin
    int c0;
    exp_t e;
    clear = 1'b0;
    start = 1'b0;
    num   = 7'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {3'd0, ready}, 4'd0);
    check("reset_result", result, 4'd0);

    @(negedge clk);
    clear = 1'b1;
    launch(7'd2, 4'd1, "num2");

    // Pulse clear low between operations, then launch 25.
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clear_pulse_ready", {3'd0, ready}, 4'd0);
    check("clear_pulse_result", result, 4'd0);
    @(negedge clk);
    clear = 1'b1;
    launch(7'd25, 4'd5, "num25");

    // Back-to-back boundary values through DONE->IDLE.
    launch(7'd127, 4'd11, "num127");
    launch(7'd0,   4'd0,  "num0");
    launch(7'd64,  4'd8,  "num64");
    launch(7'd63,  4'd7,  "num63");
    launch(7'd1,   4'd1,  "num1");
    launch(7'd3,   4'd1,  "num3");
    launch(7'd4,   4'd2,  "num4");
    launch(7'd15,  4'd3,  "num15");
    launch(7'd120, 4'd10, "num120");
    launch(7'd121, 4'd11, "num121");

    // Operand changes during CALC are ignored (launch drives num=0x55 after).
    @(negedge clk);
    start = 1'b1; num = 7'd100;
    e.root = 4'd10; e.launch_cyc = cyc + 1; e.n = 7'd100;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0; num = 7'd3;
    @(negedge clk);
    start = 1'b1;
    wait_ready("num100");
    start = 1'b0;

    // Abort on the 2nd CALC cycle: result must drop to 0 immediately.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; num = 7'd81;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("abort_ready", {3'd0, ready}, 4'd0);
    check("abort_result", result, 4'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_stale_ready", {3'd0, ready}, 4'd0);
    launch(7'd81, 4'd9, "num81_relaunch");

    // Start held high through reset launches on first edge after release.
    @(negedge clk);
    clear = 1'b0;
    start = 1'b1;
    num   = 7'd36;
    @(negedge clk);
    clear = 1'b1;
    e.root = 4'd6; e.launch_cyc = cyc + 1; e.n = 7'd36;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_ready("num36_held_reset");

    // Held start after completion: exactly one computation.
    @(negedge clk);
    @(negedge clk);
    c0 = completions;
    start = 1'b1; num = 7'd49;
    e.root = 4'd7; e.launch_cyc = cyc + 1; e.n = 7'd49;
    sb_q.push_back(e);
    repeat (15) @(negedge clk);
    check("held_start_completions", 4'(completions - c0), 4'd1);
    check("held_start_ready", {3'd0, ready}, 4'd1);
    check("held_start_result", result, 4'd7);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_idle_result", result, 4'd7);
    check("scoreboard_empty", 4'(sb_q.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/sqrt_top.md
SQRT_TOP -- requirements
Module: sqrt_top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low; clear=0 forces reset immediately, independent of clk.
REQ-004 start  input  1  launch request, sampled on rising clk.
REQ-005 num  input  7  unsigned radicand, 0..127, sampled only on the launch edge.
REQ-006 ready  output  1  registered; high = result holds a valid root for the last launched operand.
REQ-007 result  output  4  registered unsigned integer square root, 0..11.

Function
REQ-008 The block SHALL compute result = floor(sqrt(num)), i.e. the largest r with r*r <= num.
REQ-009 FSM states SHALL be IDLE, CALC, DONE, encoded in a 2-bit state register.
REQ-010 Launch: a rising edge with start=1 in IDLE SHALL capture num into an operand register, clear the root register to 0, load bit index 3, clear ready, and enter CALC.
REQ-011 CALC SHALL resolve one root bit per cycle, MSB first: trial = root with bit i set; keep that bit iff trial*trial <= operand; then decrement i.
REQ-012 Squaring/compare SHALL use at least 8-bit unsigned arithmetic, with no overflow for trial up to 15.
REQ-013 After bit 0 is resolved (4th CALC edge), the same edge SHALL load result with the final root, set ready=1, and enter DONE.
REQ-014 Latency SHALL be fixed at 4 clock cycles from launch edge to ready=1, independent of num.
REQ-015 In DONE, the block SHALL stay while start=1 and move to IDLE on the first edge with start=0; a held start SHALL NOT retrigger.
REQ-016 result and ready SHALL hold their values through DONE and IDLE until the next launch edge, which clears ready; result keeps its previous value until the new completion edge.
REQ-017 start and num changes during CALC SHALL be ignored; the captured operand SHALL be used.
REQ-018 start=0 in IDLE SHALL leave all registers unchanged.
REQ-019 Boundary values: num=0 -> 0; num=127 -> 11; perfect squares (1,4,...,121) SHALL return the exact root; num=k*k-1 SHALL return k-1.

Reset
REQ-020 While clear=0, state SHALL be IDLE, ready=0, result=0, and operand, root and bit index SHALL be 0, regardless of clk or start.
REQ-021 Assertion of clear during CALC SHALL abort the operation immediately; no stale result SHALL appear after release.
REQ-022 After clear returns high, the first rising edge with start=1 SHALL launch normally, including when start was held high through the reset.

Verification
REQ-023 Reset then launch num=2 (7'b0000010) -> ready=1 exactly 4 cycles after the launch edge, result=1.
REQ-024 Pulse clear low, then launch num=25 (7'b0011001) -> ready=0 during CALC, then ready=1 with result=5 after 4 cycles.
REQ-025 Launch num=127, then num=0, then num=64, then num=63 back-to-back via DONE->IDLE -> results 11, 0, 8, 7, each with 4-cycle latency.
REQ-026 Launch num=100, then change num to 3 during CALC -> result=10; num change ignored.
REQ-027 Launch num=81, assert clear on the 2nd CALC cycle -> ready=0 and result=0 immediately; re-launch num=81 -> result=9.
REQ-028 Hold start=1 for 10 cycles after completion -> exactly one computation; ready stays 1 and result is unchanged.
